pulse_width_modulation_meas: RTL and testbench

PULSE_WIDTH_MODULATION_MEAS -- requirements
Module: pulse_width_modulation_meas

---
 rtl/pulse_width_modulation_meas.sv | 180 ++++++++++++++++++
 tb/tb_pulse_width_modulation_meas.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_width_modulation_meas.sv
// rtl/pulse_width_modulation_meas.sv - PWM duty/period measurement with stuck-high/low detection
module pulse_width_modulation_meas #(
    parameter int BIT_WIDTH = 8,
    parameter int PWM_FREQ  = 100,
    parameter int SYS_FREQ  = 50000000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pwm_in,
    output logic [BIT_WIDTH-1:0] duty,
    output logic [BIT_WIDTH+1:0] period,
    output logic                 meas_valid,
    output logic                 stuck_hi,
    output logic                 stuck_lo
);

    localparam int RES_RAW = (SYS_FREQ / PWM_FREQ) / (2 ** BIT_WIDTH);
    localparam int RES     = (RES_RAW < 1) ? 1 : RES_RAW;
    localparam int PW      = (RES > 1) ? $clog2(RES) : 1;
    localparam int CW      = BIT_WIDTH + 2;

    localparam logic [PW-1:0]        PRESC_LAST = PW'(RES - 1);
    localparam logic [CW-1:0]        T_VAL      = CW'(2 ** (BIT_WIDTH + 1));
    localparam logic [CW-1:0]        T_LAST     = CW'((2 ** (BIT_WIDTH + 1)) - 1);
    localparam logic [CW-1:0]        CNT_MAX    = {CW{1'b1}};
    localparam logic [BIT_WIDTH-1:0] DUTY_MAX   = {BIT_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        WAIT_RISE = 2'd0,
        HIGH      = 2'd1,
        LOW       = 2'd2
    } state_t;

    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_sync_d;
    logic [PW-1:0]        r_presc;
    logic [CW-1:0]        r_tcnt;
    logic [CW-1:0]        r_hcnt;
    logic [CW-1:0]        r_pcnt;
    state_t               r_state;
    logic [BIT_WIDTH-1:0] r_duty;
    logic [CW-1:0]        r_period;
    logic                 r_valid;
    logic                 r_stuck_hi;
    logic                 r_stuck_lo;

    logic                 w_rise;
    logic                 w_fall;
    logic                 w_tick_raw;
    logic                 w_tick;
    logic [CW-1:0]        w_hcnt_inc;
    logic [CW-1:0]        w_pcnt_inc;
    logic [CW-1:0]        w_pcnt_close;
    logic [BIT_WIDTH-1:0] w_hcnt_duty;
    logic                 w_to_hi;
    logic                 w_to_lo;

    assign w_rise     = r_sync2 & ~r_sync_d;
    assign w_fall     = ~r_sync2 & r_sync_d;
    assign w_tick_raw = (r_presc == PRESC_LAST);
    assign w_tick     = w_tick_raw & ~w_rise;

    assign w_hcnt_inc  = (r_hcnt == CNT_MAX) ? r_hcnt : r_hcnt + CW'(1);
    assign w_pcnt_inc  = (r_pcnt == CNT_MAX) ? r_pcnt : r_pcnt + CW'(1);
    // The tick swallowed by a closing rise still belongs to the period it ends.
    assign w_pcnt_close = w_tick_raw ? w_pcnt_inc : r_pcnt;
    assign w_hcnt_duty  = (r_hcnt > {2'b00, DUTY_MAX}) ? DUTY_MAX : r_hcnt[BIT_WIDTH-1:0];

    assign w_to_hi = w_tick && (r_hcnt == T_LAST);
    assign w_to_lo = w_tick && !w_fall && (r_tcnt == T_LAST);

    assign duty       = r_duty;
    assign period     = r_period;
    assign meas_valid = r_valid;
    assign stuck_hi   = r_stuck_hi;
    assign stuck_lo   = r_stuck_lo;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_sync_d <= 1'b0;
        end else begin
            r_sync1  <= pwm_in;
            r_sync2  <= r_sync1;
            r_sync_d <= r_sync2;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_presc <= '0;
        end else if (w_rise || w_tick_raw) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    // Ticks since the most recent strobe of either polarity; saturates at the timeout.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tcnt <= '0;
        end else if (w_rise || w_fall) begin
            r_tcnt <= '0;
        end else if (w_tick && (r_tcnt != T_VAL)) begin
            r_tcnt <= r_tcnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= WAIT_RISE;
            r_hcnt     <= '0;
            r_pcnt     <= '0;
            r_duty     <= '0;
            r_period   <= '0;
            r_valid    <= 1'b0;
            r_stuck_hi <= 1'b0;
            r_stuck_lo <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                WAIT_RISE: begin
                    if (w_rise) begin
                        r_state    <= HIGH;
                        r_hcnt     <= '0;
                        r_pcnt     <= '0;
                        r_stuck_hi <= 1'b0;
                        r_stuck_lo <= 1'b0;
                    end else if (w_to_lo) begin
                        r_stuck_lo <= 1'b1;
                        r_stuck_hi <= 1'b0;
                        r_duty     <= '0;
                    end
                end
                HIGH: begin
                    if (w_to_hi) begin
                        r_stuck_hi <= 1'b1;
                        r_stuck_lo <= 1'b0;
                        r_duty     <= DUTY_MAX;
                        r_state    <= WAIT_RISE;
                    end else begin
                        if (w_tick) begin
                            r_hcnt <= w_hcnt_inc;
                            r_pcnt <= w_pcnt_inc;
                        end
                        if (w_fall) begin
                            r_state <= LOW;
                        end
                    end
                end
                LOW: begin
                    if (w_rise) begin
                        r_duty     <= w_hcnt_duty;
                        r_period   <= w_pcnt_close;
                        r_valid    <= 1'b1;
                        r_hcnt     <= '0;
                        r_pcnt     <= '0;
                        r_stuck_hi <= 1'b0;
                        r_stuck_lo <= 1'b0;
                        r_state    <= HIGH;
                    end else if (w_to_lo) begin
                        r_stuck_lo <= 1'b1;
                        r_stuck_hi <= 1'b0;
                        r_duty     <= '0;
                        r_state    <= WAIT_RISE;
                    end else if (w_tick) begin
                        r_pcnt <= w_pcnt_inc;
                    end
                end
                default: begin
                    r_state <= WAIT_RISE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_width_modulation_meas.sv
// tb/tb_pulse_width_modulation_meas.sv - randomized bench with event-time reference model
module tb_pulse_width_modulation_meas;

    localparam int BW  = 8;
    localparam int TMO = 512;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          pwm_in = 1'b0;
    logic [BW-1:0] duty;
    logic [BW+1:0] period;
    logic          meas_valid;
    logic          stuck_hi;
    logic          stuck_lo;

    pulse_width_modulation_meas #(
        .BIT_WIDTH(BW),
        .PWM_FREQ (100),
        .SYS_FREQ (25600)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pwm_in    (pwm_in),
        .duty      (duty),
        .period    (period),
        .meas_valid(meas_valid),
        .stuck_hi  (stuck_hi),
        .stuck_lo  (stuck_lo)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: expressed as times of strobes, not as a state machine.
    int edge_n     = 0;
    bit hist[$]    = '{1'b0, 1'b0, 1'b0, 1'b0};
    bit measuring  = 1'b0;
    int t_rise     = 0;
    int t_fall     = -1;
    int t_strobe   = 0;
    int exp_duty   = 0;
    int exp_period = 0;
    int exp_valid  = 0;
    int exp_shi    = 0;
    int exp_slo    = 0;

    task automatic model_step();
        bit rise;
        bit fall;
        bit in_high;
        edge_n++;
        if (!reset) begin
            hist       = '{1'b0, 1'b0, 1'b0, 1'b0};
            measuring  = 1'b0;
            t_fall     = -1;
            t_strobe   = edge_n;
            exp_duty   = 0;
            exp_period = 0;
            exp_valid  = 0;
            exp_shi    = 0;
            exp_slo    = 0;
        end else begin
            hist.push_front(pwm_in);
            void'(hist.pop_back());
            rise      = hist[2] && !hist[3];
            fall      = !hist[2] && hist[3];
            in_high   = measuring && (t_fall < 0);
            exp_valid = 0;
            if (rise) begin
                if (measuring && t_fall >= 0) begin
                    exp_duty   = (t_fall - t_rise > 255) ? 255 : (t_fall - t_rise);
                    exp_period = edge_n - t_rise;
                    exp_valid  = 1;
                end
                measuring = 1'b1;
                t_rise    = edge_n;
                t_fall    = -1;
                t_strobe  = edge_n;
                exp_shi   = 0;
                exp_slo   = 0;
            end else begin
                if (in_high && (edge_n - t_rise == TMO)) begin
                    exp_shi   = 1;
                    exp_slo   = 0;
                    exp_duty  = 255;
                    measuring = 1'b0;
                end else if (in_high && fall) begin
                    t_fall = edge_n;
                end else if (!in_high && !fall && (edge_n - t_strobe == TMO)) begin
                    exp_slo   = 1;
                    exp_shi   = 0;
                    exp_duty  = 0;
                    measuring = 1'b0;
                end
                if (fall) t_strobe = edge_n;
            end
        end
    endtask

    int valid_count      = 0;
    int first_valid_edge = -1;
    int last_valid_edge  = -1;
    int cap_duty         = 0;
    int cap_period       = 0;

    always @(posedge clk) begin
        model_step();
        #1;
        check("duty", 32'(duty), exp_duty);
        check("period", 32'(period), exp_period);
        check("meas_valid", 32'(meas_valid), exp_valid);
        check("stuck_hi", 32'(stuck_hi), exp_shi);
        check("stuck_lo", 32'(stuck_lo), exp_slo);
        if (meas_valid === 1'b1) begin
            valid_count++;
            if (valid_count == 1) first_valid_edge = edge_n;
            last_valid_edge = edge_n;
            cap_duty        = 32'(duty);
            cap_period      = 32'(period);
        end
    end

    int last_rise_ref = 0;
    int rise_refs[$];

    task automatic drive(input int hi, input int lo);
        pwm_in        = 1'b1;
        last_rise_ref = edge_n;
        rise_refs.push_back(edge_n);
        repeat (hi) @(negedge clk);
        pwm_in = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic wait_stuck(input bit want_hi, input int budget, output int at_edge);
        int n;
        n       = 0;
        at_edge = -1;
        while (n < budget) begin
            @(negedge clk);
            n++;
            if ((want_hi ? stuck_hi : stuck_lo) === 1'b1) begin
                at_edge = edge_n;
                break;
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_duty"}, 32'(duty), 0);
        check({tag, "_period"}, 32'(period), 0);
        check({tag, "_valid"}, 32'(meas_valid), 0);
        check({tag, "_stuck_hi"}, 32'(stuck_hi), 0);
        check({tag, "_stuck_lo"}, 32'(stuck_lo), 0);
    endtask

    initial begin
        int rel;
        int at;
        int hi;
        int lo;

        #2 reset = 1'b0;
        #1 check_all_zero("reset_initial");
        repeat (3) @(negedge clk);

        // Held low from release: stuck_lo after exactly 512 ticks.
        reset = 1'b1;
        rel   = edge_n;
        wait_stuck(1'b0, 600, at);
        check("stuck_lo_latency", at - rel, 512);
        check("stuck_lo_duty", 32'(duty), 0);
        check("stuck_lo_no_hi", 32'(stuck_hi), 0);

        // 25% duty, 64/192.
        valid_count = 0;
        repeat (5) drive(64, 192);
        check("d25_valid_count", valid_count, 4);
        check("d25_duty", cap_duty, 64);
        check("d25_period", cap_period, 256);
        check("d25_latency", last_valid_edge - last_rise_ref, 3);
        check("d25_stuck_lo_cleared", 32'(stuck_lo), 0);

        // Full scale, 300/20: high time saturates the duty.
        valid_count = 0;
        repeat (3) drive(300, 20);
        pwm_in        = 1'b1;
        last_rise_ref = edge_n;
        repeat (10) @(negedge clk);
        check("fs_valid_count", valid_count, 4);
        check("fs_duty", cap_duty, 255);
        check("fs_period", cap_period, 320);
        check("fs_stuck_hi", 32'(stuck_hi), 0);
        check("fs_stuck_lo", 32'(stuck_lo), 0);

        // Stuck high: held since the last rise.
        valid_count = 0;
        wait_stuck(1'b1, 600, at);
        check("stuck_hi_latency", at - last_rise_ref, 515);
        check("stuck_hi_duty", 32'(duty), 255);
        check("stuck_hi_no_lo", 32'(stuck_lo), 0);
        pwm_in = 1'b0;
        repeat (100) @(negedge clk);
        check("stuck_hi_held", 32'(stuck_hi), 1);
        pwm_in = 1'b1;
        repeat (5) @(negedge clk);
        check("stuck_hi_cleared", 32'(stuck_hi), 0);
        check("stuck_hi_no_valid", valid_count, 0);

        // Reset in the middle of a high phase.
        pwm_in = 1'b0;
        repeat (50) @(negedge clk);
        pwm_in = 1'b1;
        repeat (30) @(negedge clk);
        reset = 1'b0;
        #1 check_all_zero("reset_mid_high");
        @(negedge clk);
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        reset       = 1'b1;
        valid_count = 0;
        rise_refs.delete();
        repeat (3) drive(128, 128);
        check("rst_valid_count", valid_count, 2);
        check("rst_first_valid_at_rise2", first_valid_edge - rise_refs[1], 3);
        check("rst_duty", cap_duty, 128);
        check("rst_period", cap_period, 256);

        // Randomized waveforms with occasional resets, checked by the model.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                reset = 1'b0;
                repeat ($urandom_range(1, 4)) @(negedge clk);
                reset = 1'b1;
            end
            hi = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : int'($urandom_range(1, 600));
            lo = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : int'($urandom_range(1, 700));
            drive(hi, lo);
        end
        repeat (10) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
